// File: rtl/cve2_mem_arbiter.sv
// Round-robin arbiter between instruction and data ports onto one memory port,
// with an in-order ID FIFO that routes memory responses back to their source.
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic [2:0]  outstanding_o,
  output logic        protocol_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } state_e;

  state_e      state_r, state_next_s;
  logic        last_grant_r;
  logic [3:0]  ids_r;
  logic [1:0]  wr_ptr_r, rd_ptr_r;
  logic [2:0]  count_r;
  logic        protocol_err_r;
  logic        sel_instr_s, sel_data_s;
  logic        full_s, empty_s, push_s, pop_s, head_id_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == 2'(MaxOutstanding - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign full_s  = (count_r == 3'(MaxOutstanding));
  assign empty_s = (count_r == 3'd0);

  // Source selection and next-state logic; a full FIFO blocks issue and freezes the FSM.
  always_comb begin
    sel_instr_s  = 1'b0;
    sel_data_s   = 1'b0;
    state_next_s = state_r;
    if (rst_i) begin
      state_next_s = IDLE;
    end else if (full_s) begin
      state_next_s = state_r;
    end else begin
      case (state_r)
        IDLE: begin
          if (instr_req_i && data_req_i) begin
            if (last_grant_r) begin
              sel_instr_s = 1'b1;
            end else begin
              sel_data_s = 1'b1;
            end
          end else if (instr_req_i) begin
            sel_instr_s = 1'b1;
          end else if (data_req_i) begin
            sel_data_s = 1'b1;
          end else begin
            sel_instr_s = 1'b0;
          end
          if ((sel_instr_s || sel_data_s) && !mem_gnt_i) begin
            state_next_s = sel_instr_s ? HOLD_I : HOLD_D;
          end else begin
            state_next_s = IDLE;
          end
        end
        HOLD_I: begin
          sel_instr_s = instr_req_i;
          if (!instr_req_i || mem_gnt_i) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = HOLD_I;
          end
        end
        HOLD_D: begin
          sel_data_s = data_req_i;
          if (!data_req_i || mem_gnt_i) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = HOLD_D;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  assign mem_req_o   = sel_instr_s | sel_data_s;
  assign mem_we_o    = sel_data_s & data_we_i;
  assign mem_be_o    = sel_data_s ? data_be_i : (sel_instr_s ? 4'hF : 4'h0);
  assign mem_addr_o  = sel_data_s ? data_addr_i : (sel_instr_s ? instr_addr_i : 32'h0);
  assign mem_wdata_o = sel_data_s ? data_wdata_i : 32'h0;
  assign instr_gnt_o = sel_instr_s & mem_gnt_i;
  assign data_gnt_o  = sel_data_s & mem_gnt_i;

  assign push_s    = mem_req_o & mem_gnt_i;
  assign pop_s     = mem_rvalid_i & ~empty_s & ~rst_i;
  assign head_id_s = ids_r[rd_ptr_r];

  assign instr_rvalid_o = pop_s & ~head_id_s;
  assign data_rvalid_o  = pop_s & head_id_s;
  assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : 32'h0;
  assign instr_err_o    = instr_rvalid_o & mem_err_i;
  assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : 32'h0;
  assign data_err_o     = data_rvalid_o & mem_err_i;

  assign outstanding_o  = rst_i ? 3'd0 : count_r;
  assign protocol_err_o = protocol_err_r & ~rst_i;

  // FSM, round-robin history, ID FIFO and sticky protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      last_grant_r   <= 1'b0;
      ids_r          <= 4'h0;
      wr_ptr_r       <= 2'd0;
      rd_ptr_r       <= 2'd0;
      count_r        <= 3'd0;
      protocol_err_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (push_s) begin
        ids_r[wr_ptr_r] <= sel_data_s;
        wr_ptr_r        <= ptr_inc(wr_ptr_r);
        last_grant_r    <= sel_data_s;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 3'd1;
        2'b01:   count_r <= count_r - 3'd1;
        default: count_r <= count_r;
      endcase
      if (mem_rvalid_i && empty_s) begin
        protocol_err_r <= 1'b1;
      end else begin
        protocol_err_r <= protocol_err_r;
      end
    end
  end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Directed self-checking bench for cve2_mem_arbiter (MaxOutstanding = 2).
module tb_cve2_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid, mem_err;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  outstanding;
  logic        protocol_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cve2_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
    .outstanding_o(outstanding), .protocol_err_o(protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_err = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    // Reset with every request and response active: outputs must stay quiet.
    instr_req = 1'b1; instr_addr = 32'h100; data_req = 1'b1; data_addr = 32'h200;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h99;
    #2;
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_instr_gnt", instr_gnt, 1'b0);
    chk("rst_data_gnt", data_gnt, 1'b0);
    chk("rst_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
    chk("rst_mem_addr", mem_addr, 32'h0);
    tick(); tick();
    chk("rst_outstanding", outstanding, 3'd0);
    chk("rst_perr", protocol_err, 1'b0);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("post_rst_outstanding", outstanding, 3'd0);
    chk("post_rst_perr", protocol_err, 1'b0);

    // Both requesting, grant always: data first, then instr, then saturation.
    instr_req = 1'b1; instr_addr = 32'h100;
    data_req = 1'b1; data_addr = 32'h200; data_we = 1'b1; data_be = 4'h3; data_wdata = 32'hDEAD;
    mem_gnt = 1'b1;
    #1;
    chk("rr0_mem_req", mem_req, 1'b1);
    chk("rr0_gnts", {instr_gnt, data_gnt}, 2'b01);
    chk("rr0_addr", mem_addr, 32'h200);
    chk("rr0_we_be", {mem_we, mem_be}, 5'b1_0011);
    chk("rr0_wdata", mem_wdata, 32'hDEAD);
    tick();
    chk("rr1_outstanding", outstanding, 3'd1);
    chk("rr1_gnts", {instr_gnt, data_gnt}, 2'b10);
    chk("rr1_addr", mem_addr, 32'h100);
    chk("rr1_we_be", {mem_we, mem_be}, 5'b0_1111);
    chk("rr1_wdata", mem_wdata, 32'h0);
    tick();
    chk("sat_outstanding", outstanding, 3'd2);
    chk("sat_mem_req", mem_req, 1'b0);
    chk("sat_gnts", {instr_gnt, data_gnt}, 2'b00);
    chk("sat_addr", mem_addr, 32'h0);

    // Pop while full: response goes to data (oldest), no bypass issue.
    mem_rvalid = 1'b1; mem_rdata = 32'h22;
    #1;
    chk("full_pop_mem_req", mem_req, 1'b0);
    chk("full_pop_rvalid", {instr_rvalid, data_rvalid}, 2'b01);
    chk("full_pop_data_rdata", data_rdata, 32'h22);
    chk("full_pop_instr_rdata", instr_rdata, 32'h0);
    tick();
    chk("after_pop_outstanding", outstanding, 3'd1);
    // Push and pop together; last grant was instr so data wins.
    mem_rdata = 32'h11; mem_err = 1'b1;
    #1;
    chk("pp_gnts", {instr_gnt, data_gnt}, 2'b01);
    chk("pp_rvalid", {instr_rvalid, data_rvalid}, 2'b10);
    chk("pp_instr_rdata_err", {instr_err, instr_rdata}, {1'b1, 32'h11});
    chk("pp_data_err", data_err, 1'b0);
    tick();
    chk("pp_outstanding", outstanding, 3'd1);
    mem_rvalid = 1'b0; mem_err = 1'b0;
    #1;
    chk("alt_gnts", {instr_gnt, data_gnt}, 2'b10);
    tick();
    chk("alt_outstanding", outstanding, 3'd2);
    clear_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h33;
    #1;
    chk("drain1_rvalid", {instr_rvalid, data_rvalid}, 2'b01);
    tick();
    mem_rdata = 32'h44;
    #1;
    chk("drain2_rvalid", {instr_rvalid, data_rvalid}, 2'b10);
    chk("drain2_rdata", instr_rdata, 32'h44);
    tick();
    clear_inputs();
    #1;
    chk("drained_outstanding", outstanding, 3'd0);

    // Data held without grant for three cycles, instr joins on cycle 1.
    data_req = 1'b1; data_addr = 32'h300;
    #1;
    chk("hold0_req_addr", {mem_req, mem_addr}, {1'b1, 32'h300});
    tick();
    instr_req = 1'b1; instr_addr = 32'h100;
    #1;
    chk("hold1_addr", mem_addr, 32'h300);
    chk("hold1_instr_gnt", instr_gnt, 1'b0);
    tick();
    chk("hold2_addr", mem_addr, 32'h300);
    chk("hold2_instr_gnt", instr_gnt, 1'b0);
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("hold3_gnts", {instr_gnt, data_gnt}, 2'b01);
    chk("hold3_addr", mem_addr, 32'h300);
    tick();
    chk("hold4_gnts", {instr_gnt, data_gnt}, 2'b10);
    chk("hold4_addr", mem_addr, 32'h100);
    tick();
    clear_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h55;
    #1;
    chk("drain3_rvalid", {instr_rvalid, data_rvalid}, 2'b01);
    tick();
    mem_rdata = 32'h66;
    tick();
    clear_inputs();
    #1;
    chk("drained2_outstanding", outstanding, 3'd0);

    // In-order response routing: instr at 0x100, then data write at 0x200.
    instr_req = 1'b1; instr_addr = 32'h100; mem_gnt = 1'b1;
    #1;
    chk("ord_instr_gnt", instr_gnt, 1'b1);
    tick();
    instr_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h200; data_we = 1'b1; data_be = 4'h3;
    #1;
    chk("ord_data_fields", {data_gnt, mem_we, mem_be, mem_addr}, {1'b1, 1'b1, 4'h3, 32'h200});
    tick();
    clear_inputs();
    mem_rvalid = 1'b1; mem_rdata = 32'h11;
    #1;
    chk("ord_first", {instr_rvalid, data_rvalid, instr_rdata}, {2'b10, 32'h11});
    tick();
    mem_rdata = 32'h22;
    #1;
    chk("ord_second", {instr_rvalid, data_rvalid, data_rdata}, {2'b01, 32'h22});
    tick();
    clear_inputs();

    // HOLD_I ignores data, and instr dropping its request returns to IDLE.
    instr_req = 1'b1; instr_addr = 32'h400;
    #1;
    chk("hi0_addr", mem_addr, 32'h400);
    tick();
    instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h500;
    #1;
    chk("hi1_mem_req", mem_req, 1'b0);
    chk("hi1_addr", mem_addr, 32'h0);
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("hi2_data_gnt", {data_gnt, mem_addr}, {1'b1, 32'h500});
    tick();
    data_req = 1'b0; instr_req = 1'b1;
    #1;
    chk("hi3_instr_gnt", instr_gnt, 1'b1);
    tick();
    chk("hi3_outstanding", outstanding, 3'd2);

    // Full with simultaneous pop and new data request: issue waits a cycle.
    instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h600; data_we = 1'b0; data_be = 4'hF;
    mem_rvalid = 1'b1; mem_rdata = 32'h77;
    #1;
    chk("nb_mem_req", mem_req, 1'b0);
    chk("nb_data_gnt", data_gnt, 1'b0);
    chk("nb_rvalid", {instr_rvalid, data_rvalid}, 2'b01);
    tick();
    chk("nb_outstanding", outstanding, 3'd1);
    mem_rvalid = 1'b0;
    #1;
    chk("nb_issue", {mem_req, data_gnt, mem_addr}, {2'b11, 32'h600});
    tick();
    chk("nb_outstanding2", outstanding, 3'd2);

    // Reset pulse with two outstanding discards them; next response is a protocol error.
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", mem_req, 1'b0);
    chk("mid_rst_outstanding", outstanding, 3'd0);
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    chk("mid_post_outstanding", outstanding, 3'd0);
    chk("mid_post_perr", protocol_err, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'h88;
    #1;
    chk("stray_rvalid", {instr_rvalid, data_rvalid}, 2'b00);
    chk("stray_perr_same_cycle", protocol_err, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("stray_perr_set", protocol_err, 1'b1);
    tick(); tick();
    chk("stray_perr_sticky", protocol_err, 1'b1);
    chk("stray_outstanding", outstanding, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("perr_cleared", protocol_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cve2_mem_arbiter.md
CVE2_MEM_ARBITER -- requirements
Module: cve2_mem_arbiter

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, legal 1..4: max accepted-but-unanswered mem transactions.
REQ-002 SHALL have ports clk_i (in, 1) clock and rst_i (in, 1) reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have instr_req_i in 1, instr_gnt_o out 1, instr_addr_i in 32: instruction request, grant and address.
REQ-004 SHALL have instr_rvalid_o out 1, instr_rdata_o out 32, instr_err_o out 1: instruction response.
REQ-005 SHALL have data_req_i in 1, data_gnt_o out 1, data_we_i in 1, data_be_i in 4, data_addr_i in 32, data_wdata_i in 32: data request.
REQ-006 SHALL have data_rvalid_o out 1, data_rdata_o out 32, data_err_o out 1: data response.
REQ-007 SHALL have mem_req_o out 1, mem_gnt_i in 1, mem_we_o out 1, mem_be_o out 4, mem_addr_o out 32, mem_wdata_o out 32: shared memory request.
REQ-008 SHALL have mem_rvalid_i in 1, mem_rdata_i in 32, mem_err_i in 1: shared memory response.
REQ-009 SHALL have outstanding_o out 3: current outstanding count, and protocol_err_o out 1: sticky unexpected-response flag.

Function
REQ-010 SHALL implement arbitration FSM with states IDLE, HOLD_I and HOLD_D.
REQ-011 In IDLE, a single requester SHALL be selected combinationally: zero-cycle req-to-mem_req_o latency.
REQ-012 In IDLE with both requesting, the requester not in last_grant SHALL be selected (round-robin).
REQ-013 Selected request not granted (mem_gnt_i=0) SHALL move FSM to HOLD_I/HOLD_D, keeping that requester selected.
REQ-014 In HOLD_x, mem outputs SHALL stay driven from requester x; the other requester is ignored.
REQ-015 HOLD_x SHALL return to IDLE on mem_gnt_i=1 or on x dropping its req.
REQ-016 last_grant SHALL update to the source of every mem_req_o & mem_gnt_i handshake.
REQ-017 Instr selected: mem_addr_o=instr_addr_i, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-018 Data selected: mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o SHALL equal the data_* inputs.
REQ-019 Nothing selected: mem_req_o=0 and all mem payload outputs SHALL be 0.
REQ-020 instr_gnt_o/data_gnt_o SHALL equal mem_gnt_i & mem_req_o & (source selected); never both 1.
REQ-021 Every handshake SHALL push its source ID (0=instr, 1=data) into an in-order ID FIFO of depth MaxOutstanding.
REQ-022 mem_rvalid_i=1 with FIFO non-empty SHALL pop the head and, same cycle, assert that source's rvalid_o with rdata/err = mem_rdata_i/mem_err_i.
REQ-023 Non-addressed rvalid_o SHALL be 0; rdata_o/err_o SHALL be 0 whenever the matching rvalid_o is 0.
REQ-024 With outstanding_o == MaxOutstanding, mem_req_o SHALL be 0 even if a pop occurs that cycle (no bypass); FSM state is held.
REQ-025 Simultaneous push and pop SHALL leave outstanding_o unchanged; FIFO pointers SHALL wrap modulo MaxOutstanding.
REQ-026 mem_rvalid_i=1 with FIFO empty SHALL be dropped (no rvalid_o) and SHALL set protocol_err_o, held until reset.
REQ-027 outstanding_o SHALL update registered: next cycle after push/pop.

Reset
REQ-028 With rst_i=1 at a clk_i rising edge: FSM=IDLE, FIFO empty, outstanding_o=0, last_grant=instr, protocol_err_o=0.
REQ-029 While rst_i=1, mem_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o and data_rvalid_o SHALL be 0; all other outputs 0.
REQ-030 Reset mid-transaction SHALL discard all outstanding IDs; later mem_rvalid_i with empty FIFO SHALL follow REQ-026.

Verification
REQ-031 Post-reset, instr_req_i=data_req_i=1, mem_gnt_i=1 -> data granted cycle 0, instr cycle 1, then alternating; outstanding_o saturates at 2 and mem_req_o drops.
REQ-032 data_req_i=1, mem_gnt_i=0 for 3 cycles, instr_req_i raised cycle 1 -> mem_addr_o stays data_addr_i, instr_gnt_o=0 until data granted cycle 3.
REQ-033 Grants instr(A=0x100) then data(A=0x200, we=1, be=4'h3); rvalids with rdata 0x11, 0x22 -> instr_rvalid_o with 0x11 first, then data_rvalid_o with 0x22.
REQ-034 MaxOutstanding=2, two outstanding; same cycle: mem_rvalid_i=1, new req -> mem_req_o=0 that cycle, outstanding_o=1 next, request issued next cycle.
REQ-035 mem_rvalid_i=1 with outstanding_o=0 -> no rvalid_o asserted, protocol_err_o=1 from next cycle until rst_i.
REQ-036 Two grants outstanding, rst_i pulsed 1 cycle -> outstanding_o=0, mem_req_o=0 during reset, subsequent mem_rvalid_i sets protocol_err_o.
